// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. The requester that
//   wins round-robin arbitration has its operands and function latched into
//   the ALU input registers. One cycle later the ALU result is captured and
//   returned with the winner's id.
//   Each operation goes IDLE -> EXEC -> DONE, so the block accepts at most
//   one operation every three cycles.
//
// Ports
//   clk, rstn                   clock, synchronous active-low reset
//   req0/a0/b0/func0, ack0      port 0 request, operands, grant pulse
//   req1/a1/b1/func1, ack1      port 1 request, operands, grant pulse
//   alu_a/alu_b/alu_func        registered operands/function to the ALU
//   alu_y/alu_of                combinational ALU result/overflow
//   res_y/res_of/res_id         captured result, overflow, requester id
//   res_vld                     one-cycle result-valid pulse
//   busy                        high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH  = 6,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0,
    input  logic [WIDTH-1:0]  a0,
    input  logic [WIDTH-1:0]  b0,
    input  logic [FUNC_W-1:0] func0,
    output logic              ack0,
    input  logic              req1,
    input  logic [WIDTH-1:0]  a1,
    input  logic [WIDTH-1:0]  b1,
    input  logic [FUNC_W-1:0] func1,
    output logic              ack1,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [WIDTH-1:0]  alu_y,
    input  logic              alu_of,
    output logic [WIDTH-1:0]  res_y,
    output logic              res_of,
    output logic              res_id,
    output logic              res_vld,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [FUNC_W-1:0] func;
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [WIDTH-1:0]  res_y_q, res_y_d;
    logic              res_of_q, res_of_d;
    logic              res_id_q, res_id_d;
    logic              res_vld_q, res_vld_d;
    logic [1:0]        ack_q, ack_d;
    logic              last_id_q, last_id_d;
    logic              gnt_id_q, gnt_id_d;

    op_t               port_op [2];
    logic              any_req;
    logic              gnt_sel;

    assign port_op[0] = '{a: a0, b: b0, func: func0};
    assign port_op[1] = '{a: a1, b: b1, func: func1};

    assign any_req = req0 | req1;
    // On a tie the port that did not win last time goes next. With a single
    // request, req1 alone selects port 1 and req0 alone selects port 0.
    assign gnt_sel = (req0 && req1) ? ~last_id_q : req1;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        res_y_d   = res_y_q;
        res_of_d  = res_of_q;
        res_id_d  = res_id_q;
        res_vld_d = 1'b0;
        ack_d     = 2'b00;
        last_id_d = last_id_q;
        gnt_id_d  = gnt_id_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    op_d           = port_op[gnt_sel];
                    last_id_d      = gnt_sel;
                    gnt_id_d       = gnt_sel;
                    ack_d[gnt_sel] = 1'b1;
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                // ALU inputs were registered on the grant edge, so alu_y is
                // settled for the latched operation by this edge.
                res_y_d   = alu_y;
                res_of_d  = alu_of;
                res_id_d  = gnt_id_q;
                res_vld_d = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            op_q      <= '0;
            res_y_q   <= '0;
            res_of_q  <= 1'b0;
            res_id_q  <= 1'b0;
            res_vld_q <= 1'b0;
            ack_q     <= 2'b00;
            last_id_q <= 1'b1;   // port 0 wins the first tie after reset
            gnt_id_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            res_y_q   <= res_y_d;
            res_of_q  <= res_of_d;
            res_id_q  <= res_id_d;
            res_vld_q <= res_vld_d;
            ack_q     <= ack_d;
            last_id_q <= last_id_d;
            gnt_id_q  <= gnt_id_d;
        end
    end

    assign alu_a    = op_q.a;
    assign alu_b    = op_q.b;
    assign alu_func = op_q.func;
    assign res_y    = res_y_q;
    assign res_of   = res_of_q;
    assign res_id   = res_id_q;
    assign res_vld  = res_vld_q;
    assign ack0     = ack_q[0];
    assign ack1     = ack_q[1];
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int W  = 6;
    localparam int FW = 4;

    localparam logic [FW-1:0] F_ADD = 4'd0;
    localparam logic [FW-1:0] F_SUB = 4'd1;
    localparam logic [FW-1:0] F_AND = 4'd2;
    localparam logic [FW-1:0] F_XOR = 4'd3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req0, req1;
    logic [W-1:0]  a0, b0, a1, b1;
    logic [FW-1:0] func0, func1;
    logic          ack0, ack1;
    logic [W-1:0]  alu_a, alu_b;
    logic [FW-1:0] alu_func;
    logic [W-1:0]  alu_y;
    logic          alu_of;
    logic [W-1:0]  res_y;
    logic          res_of, res_id, res_vld, busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic         id;
        logic [W-1:0] y;
        logic         of;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .FUNC_W(FW)) dut (
        .clk(clk), .rstn(rstn),
        .req0(req0), .a0(a0), .b0(b0), .func0(func0), .ack0(ack0),
        .req1(req1), .a1(a1), .b1(b1), .func1(func1), .ack1(ack1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_y(alu_y), .alu_of(alu_of),
        .res_y(res_y), .res_of(res_of), .res_id(res_id),
        .res_vld(res_vld), .busy(busy)
    );

    // Reference ALU: 6-bit two's complement add/sub with signed overflow.
    function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [FW-1:0] f);
        logic [W-1:0] y;
        logic         of;
        y  = '0;
        of = 1'b0;
        case (f)
            F_ADD: begin y = a + b; of = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]); end
            F_SUB: begin y = a - b; of = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]); end
            F_AND: y = a & b;
            F_XOR: y = a ^ b;
            default: y = '0;
        endcase
        return {of, y};
    endfunction

    always_comb begin
        {alu_of, alu_y} = alu_fn(alu_a, alu_b, alu_func);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [FW-1:0] f);
        logic [W:0] r;
        r = alu_fn(a, b, f);
        sbq.push_back('{id: id, y: r[W-1:0], of: r[W]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every result pulse must match the oldest expected entry.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (res_vld === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_res_vld", 32'(res_vld), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("res_y",  32'(res_y),  32'(e.y));
                chk("res_of", 32'(res_of), 32'(e.of));
                chk("res_id", 32'(res_id), 32'(e.id));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic gid;
        logic [W-1:0] pa0, pb0, pa1, pb1;
        rstn = 1'b0; req0 = 0; req1 = 0;
        a0 = '0; b0 = '0; func0 = F_ADD; a1 = '0; b1 = '0; func1 = F_ADD;

        // Reset, then a single add on port 0.
        tick(); tick();
        chk("rst_alu_a",   32'(alu_a), 0);
        chk("rst_alu_b",   32'(alu_b), 0);
        chk("rst_alu_func",32'(alu_func), 0);
        chk("rst_res_y",   32'(res_y), 0);
        chk("rst_res_of",  32'(res_of), 0);
        chk("rst_res_id",  32'(res_id), 0);
        chk("rst_ack",     32'({ack1, ack0}), 0);
        chk("rst_res_vld", 32'(res_vld), 0);
        chk("rst_busy",    32'(busy), 0);

        rstn = 1'b1;
        req0 = 1; a0 = 6'd5; b0 = 6'd3; func0 = F_ADD;
        sbq.push_back('{id: 1'b0, y: 6'd8, of: 1'b0});
        tick();
        chk("single_ack0", 32'(ack0), 1);
        chk("single_ack1", 32'(ack1), 0);
        chk("single_busy_exec", 32'(busy), 1);
        chk("single_alu_a", 32'(alu_a), 5);
        chk("single_vld_exec", 32'(res_vld), 0);
        req0 = 0;
        tick();
        chk("single_vld", 32'(res_vld), 1);
        chk("single_ack0_done", 32'(ack0), 0);
        chk("single_busy_done", 32'(busy), 1);
        tick();
        chk("single_vld_off", 32'(res_vld), 0);
        chk("single_busy_idle", 32'(busy), 0);
        chk("hold_res_y", 32'(res_y), 8);
        chk("hold_alu_b", 32'(alu_b), 3);

        // Overflow passthrough on port 1.
        req1 = 1; a1 = 6'd31; b1 = 6'd1; func1 = F_ADD;
        sbq.push_back('{id: 1'b1, y: 6'b100000, of: 1'b1});
        tick();
        chk("ovf_ack1", 32'(ack1), 1);
        req1 = 0;
        tick(); tick();

        // Tie after reset: port 0 first, held req1 served three cycles later.
        rstn = 1'b0; tick(); tick(); rstn = 1'b1;
        req0 = 1; a0 = 6'd12; b0 = 6'd20; func0 = F_XOR;
        req1 = 1; a1 = 6'd40; b1 = 6'd9;  func1 = F_SUB;
        push(1'b0, 6'd12, 6'd20, F_XOR);
        push(1'b1, 6'd40, 6'd9, F_SUB);
        tick();
        chk("tie_ack0", 32'(ack0), 1);
        chk("tie_ack1_early", 32'(ack1), 0);
        req0 = 0;
        tick();
        chk("tie_ack1_exec_gap", 32'(ack1), 0);
        tick();
        chk("tie_ack1_done_gap", 32'(ack1), 0);
        tick();
        chk("tie_ack1", 32'(ack1), 1);
        req1 = 0;
        tick(); tick();

        // Continuous contention: grants must alternate, one result per 3 cycles.
        pa0 = 6'd7;  pb0 = 6'd30; pa1 = 6'd33; pb1 = 6'd33;
        a0 = pa0; b0 = pb0; func0 = F_ADD;
        a1 = pa1; b1 = pb1; func1 = F_ADD;
        req0 = 1; req1 = 1;
        for (int i = 0; i < 8; i++) begin
            gid = i[0];
            if (gid) push(1'b1, a1, b1, func1);
            else     push(1'b0, a0, b0, func0);
            tick();
            chk("cont_ack_win",  32'(gid ? ack1 : ack0), 1);
            chk("cont_ack_lose", 32'(gid ? ack0 : ack1), 0);
            chk("cont_vld_ack_cycle", 32'(res_vld), 0);
            if (gid) begin req1 = 0; a1 = W'($urandom); b1 = W'($urandom); func1 = FW'($urandom_range(0, 3)); end
            else     begin req0 = 0; a0 = W'($urandom); b0 = W'($urandom); func0 = FW'($urandom_range(0, 3)); end
            tick();
            chk("cont_vld", 32'(res_vld), 1);
            if (gid) req1 = 1; else req0 = 1;
            tick();
            chk("cont_vld_idle", 32'(res_vld), 0);
        end
        req0 = 0; req1 = 0;
        tick(); tick(); tick();

        // Operand change in the ack cycle must not affect the result.
        req0 = 1; a0 = 6'd10; b0 = 6'd7; func0 = F_SUB;
        sbq.push_back('{id: 1'b0, y: 6'd3, of: 1'b0});
        tick();
        chk("chg_ack0", 32'(ack0), 1);
        req0 = 0; a0 = 6'd60; b0 = 6'd1;
        tick();
        chk("chg_vld", 32'(res_vld), 1);
        tick();

        // Reset during EXEC: no result, everything cleared, next tie to port 0.
        req0 = 1; a0 = 6'd21; b0 = 6'd22; func0 = F_AND;
        tick();
        chk("mid_ack0", 32'(ack0), 1);
        req0 = 0; rstn = 1'b0;
        tick();
        chk("mid_res_vld", 32'(res_vld), 0);
        chk("mid_busy",    32'(busy), 0);
        chk("mid_ack",     32'({ack1, ack0}), 0);
        chk("mid_alu_a",   32'(alu_a), 0);
        chk("mid_alu_func",32'(alu_func), 0);
        chk("mid_res_y",   32'(res_y), 0);
        chk("mid_res_id",  32'(res_id), 0);
        rstn = 1'b1;
        req0 = 1; a0 = 6'd63; b0 = 6'd63; func0 = F_ADD;
        req1 = 1; a1 = 6'd1;  b1 = 6'd2;  func1 = F_ADD;
        sbq.push_back('{id: 1'b0, y: 6'd62, of: 1'b0});
        tick();
        chk("mid_tie_ack0", 32'(ack0), 1);
        chk("mid_tie_ack1", 32'(ack1), 0);
        req0 = 0; req1 = 0;
        tick(); tick(); tick();

        chk("sb_empty", 32'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
